morse_serializer: RTL and testbench
===================================

# morse_serializer

Parametrised successor to the 4-bit binary-to-Morse encoder. It accepts 4-bit character codes through a handshake and buffers them in a small FIFO. Each character is then emitted as a timed serial Morse keying signal: dot = 1 unit, dash = 3 units, 1-unit intra-character space, 3-unit inter-character gap. The 5-bit parallel pattern (X1..X5 convention) is also exposed for the character currently being keyed. The block sits between the character source and the line/LED driver.

## Interface
- UNIT_CYCLES, 4: clock cycles per Morse time unit; must be ≥1.
- DEPTH, 4: input FIFO depth in characters; power of 2, ≥2.
- HEX_EN, 1: 1 = codes 10..15 map to letters A..F; 0 = codes 10..15 are rejected.
- clock  in  1  single clock, rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low.
- data  in  4  character code; bit 3 = A (MSB) … bit 0 = D.
- ready  in  1  data valid; a write is accepted on an edge where ready=1 and full=0.
- full  out  1  FIFO holds DEPTH characters.
- err  out  1  one-cycle pulse when ready=1, HEX_EN=0 and data>9.
- key  out  1  Morse keying output; 1 = tone/mark.
- pattern  out  5  elements of the current character; bit 4 = first element (X1); 1 = dash. Unused low bits = 0.
- len  out  3  number of elements in the current character, 1..5.
- busy  out  1  a character is in progress, including its trailing gap.

## Operation
- Encoding:
  - 0 = -----.
  - d in 1..5: d dots followed by dashes.
  - d in 6..9: (d−5) dashes followed by dots.
  - Letters: A=.-, B=-..., C=-.-., D=-.., E=., F=..-.
- Input:
  - Accepted write (ready & !full & code legal) pushes into the FIFO.
  - ready & full: character dropped. No err, no state change.
  - Illegal code: not queued; err=1 for exactly the next cycle.
- Engine FSM states: IDLE, LOAD, MARK, SPACE, GAP.
  - IDLE: if FIFO is non-empty, pop and go to LOAD; else stay.
  - LOAD: latch pattern/len; element index = 0; counter = UNIT_CYCLES (dot) or 3·UNIT_CYCLES (dash); go to MARK.
  - MARK: key=1; count down. On last cycle: more elements → SPACE (counter = UNIT_CYCLES); last element → GAP (counter = 3·UNIT_CYCLES).
  - SPACE: key=0; on expiry, load the next element's length → MARK.
  - GAP: key=0; on expiry → IDLE.
- Counter width: $clog2(3·UNIT_CYCLES+1). No wrap; it reloads before reaching 0.
- busy=1 in LOAD, MARK, SPACE and GAP.
- pattern/len hold their value from LOAD until the next LOAD. They are 0 after reset.
- Write and pop on the same edge: both occur; occupancy is unchanged. full is computed on the pre-edge count, so a write is refused when full even if a pop is simultaneous.
- Reset, asynchronous, at any time, including mid-mark:
  - key, busy, full, err = 0; pattern = 0; len = 0.
  - FIFO is emptied; FSM goes to IDLE.
  - A character in progress is lost.

## Timing
- Idle path: write accepted at edge t → pop at t+1 (IDLE→LOAD) → MARK entered at t+2, so key=1 from t+2.
- Mark durations: exactly UNIT_CYCLES cycles (dot) or 3·UNIT_CYCLES cycles (dash). Space: exactly UNIT_CYCLES cycles.
- Inter-character key-low time = 3·UNIT_CYCLES (GAP) + 2 (IDLE, LOAD) cycles when the FIFO is non-empty.
- full rises on the edge that writes the DEPTH-th entry. It falls on the edge of the pop that frees a slot.
- err is registered: it rises on the edge after the illegal ready cycle and lasts 1 cycle.

## Structure
- Package morse_pkg holds:
  - FSM state encoding constants.
  - The code→{pattern,len} function or constant ROM (16 entries, with a legality bit).
  - Element timing multipliers (1, 3).
- Sub-module morse_fifo: DEPTH×4 synchronous FIFO with full/empty, async active-low reset, write/pop ports.
- Top level contains the input legality check, FSM and timing counter.

## Test plan
All scenarios use UNIT_CYCLES=2 unless noted.
- Digit 1 when idle:
  - pattern=5'b01111, len=5.
  - key: 2 high, 2 low, then 6 high / 2 low ×3, then 6 high, then 6 low.
  - busy is high for 1+26+8+6=41 cycles.
- Digit 5: key sequence is five 2-cycle marks separated by 2-cycle spaces (18 cycles), then a 6-cycle gap; pattern=5'b00000, len=5.
- HEX_EN=1, data=0xE: a single 2-cycle mark; len=1; pattern=5'b00000; busy for 1+2+6=9 cycles.
- HEX_EN=0, data=0xA: err is high for 1 cycle; key stays 0; busy stays 0; the FIFO remains empty.
- DEPTH=4, six back-to-back writes (codes 0..5) while idle:
  - The first is popped on the next edge, so the FIFO fills with codes 1..4 and full=1.
  - Code 5 is dropped.
  - Codes 0,1,2,3,4 are keyed in order.
- Reset asserted mid-dash of digit 0:
  - key, busy and full go to 0 immediately without a clock.
  - After release, writing 7 produces -- ... keying that starts 2 cycles after the accept edge.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse serializer: engine states, element timing
// multipliers and the character-code to Morse-element lookup.
package morse_pkg;

    // Keying engine states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MARK  = 3'd2,
        ST_SPACE = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    // Element durations in Morse units: a dot and every space last one unit.
    // A dash and the gap between characters last three units.
    localparam int unsigned DOT_MULT  = 1;
    localparam int unsigned DASH_MULT = 3;

    // Elements of one character. Bit 4 of pattern is the first element and
    // 1 means dash. Unused low bits are 0.
    typedef struct packed {
        logic [4:0] pattern;
        logic [2:0] len;
    } code_info_t;

    // Digits 0..9 are always legal. Codes 10..15 are legal only with hex letters enabled.
    function automatic logic code_legal(input logic [3:0] code, input logic hex_en);
        return (code <= 4'd9) || hex_en;
    endfunction

    // Code to element lookup (16-entry constant ROM).
    function automatic code_info_t code_lookup(input logic [3:0] code);
        code_info_t info;
        info.pattern = 5'b00000;
        info.len     = 3'd5;
        case (code)
            4'd0:  info.pattern = 5'b11111;                       // -----
            4'd1:  info.pattern = 5'b01111;                       // .----
            4'd2:  info.pattern = 5'b00111;                       // ..---
            4'd3:  info.pattern = 5'b00011;                       // ...--
            4'd4:  info.pattern = 5'b00001;                       // ....-
            4'd5:  info.pattern = 5'b00000;                       // .....
            4'd6:  info.pattern = 5'b10000;                       // -....
            4'd7:  info.pattern = 5'b11000;                       // --...
            4'd8:  info.pattern = 5'b11100;                       // ---..
            4'd9:  info.pattern = 5'b11110;                       // ----.
            4'd10: begin info.pattern = 5'b01000; info.len = 3'd2; end // A .-
            4'd11: begin info.pattern = 5'b10000; info.len = 3'd4; end // B -...
            4'd12: begin info.pattern = 5'b10100; info.len = 3'd4; end // C -.-.
            4'd13: begin info.pattern = 5'b10000; info.len = 3'd3; end // D -..
            4'd14: begin info.pattern = 5'b00000; info.len = 3'd1; end // E .
            4'd15: begin info.pattern = 5'b00100; info.len = 3'd4; end // F ..-.
        endcase
        return info;
    endfunction

endpackage

// File: rtl/morse_fifo.sv
// Small synchronous FIFO for pending character codes. The read data is
// registered on the pop edge, so the popped entry is available one cycle later.
module morse_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] rd_data_q;
    logic             do_push;
    logic             do_pop;

    // Flags come from the pre-edge occupancy. A push is refused when full even if a pop occurs on the same edge.
    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = rd_data_q;

    // Pointer and occupancy next-state; pointers wrap since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array without reset, so it can map onto RAM.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Control registers and the registered read port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_pop) begin
                rd_data_q <= mem_q[rd_ptr_q];
            end
        end
    end

endmodule

// File: rtl/morse_serializer.sv
// Buffers 4-bit character codes and keys each one out as timed Morse:
// dot = 1 unit, dash = 3 units, 1-unit element space, 3-unit character gap.
module morse_serializer
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 4,
    parameter int unsigned DEPTH       = 4,
    parameter bit          HEX_EN      = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] data_i,
    input  logic       ready_i,
    output logic       full_o,
    output logic       err_o,
    output logic       key_o,
    output logic [4:0] pattern_o,
    output logic [2:0] len_o,
    output logic       busy_o
);

    localparam int unsigned CNT_W = $clog2(3 * UNIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] DOT_CNT  = CNT_W'(DOT_MULT * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] DASH_CNT = CNT_W'(DASH_MULT * UNIT_CYCLES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [4:0]       pattern_q, pattern_d;
    logic [2:0]       len_q, len_d;
    logic             err_q;

    logic             in_legal;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [3:0]       fifo_rdata;
    code_info_t       load_info;

    // Illegal codes are never queued. Legal codes are dropped silently when the FIFO is full.
    assign in_legal  = code_legal(data_i, HEX_EN);
    assign fifo_push = ready_i && in_legal && !fifo_full;
    assign load_info = code_lookup(fifo_rdata);

    morse_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (fifo_push),
        .push_data_i (data_i),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_rdata),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign full_o    = fifo_full;
    assign err_o     = err_q;
    assign pattern_o = pattern_q;
    assign len_o     = len_q;

    // Engine next-state, element sequencing and keying outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        fifo_pop  = 1'b0;
        key_o     = 1'b0;
        busy_o    = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // fifo_rdata holds the code popped on the previous edge.
                pattern_d = load_info.pattern;
                len_d     = load_info.len;
                idx_d     = 3'd0;
                cnt_d     = load_info.pattern[4] ? DASH_CNT : DOT_CNT;
                state_d   = ST_MARK;
            end
            ST_MARK: begin
                key_o = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    if (idx_q != len_q - 3'd1) begin
                        cnt_d   = DOT_CNT;
                        state_d = ST_SPACE;
                    end else begin
                        cnt_d   = DASH_CNT;
                        state_d = ST_GAP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SPACE: begin
                if (cnt_q == CNT_W'(1)) begin
                    // The next element sits one position below the current one.
                    idx_d   = idx_q + 3'd1;
                    cnt_d   = pattern_q[3'd3 - idx_q] ? DASH_CNT : DOT_CNT;
                    state_d = ST_MARK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Engine registers plus the one-cycle illegal-code flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            pattern_q <= '0;
            len_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            err_q     <= ready_i && !in_legal;
        end
    end

endmodule

// File: tb/tb_morse_serializer.sv
// Bench for morse_serializer (UNIT_CYCLES=2, DEPTH=4). A dot/dash-string
// reference model predicts every output cycle by cycle. Directed scenarios pin
// the model with hand-computed keying strings, patterns and latencies.
`timescale 1ns/1ps
module tb_morse_serializer;

    localparam int U     = 2;
    localparam int DEPTH = 4;
    localparam byte DASH_CH = 8'h2D; // '-'

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] data = 4'd0;
    logic       ready = 1'b0;
    logic       full, err, key, busy;
    logic [4:0] pattern;
    logic [2:0] len;

    logic [3:0] data2 = 4'd0;
    logic       ready2 = 1'b0;
    logic       full2, err2, key2, busy2;
    logic [4:0] pattern2;
    logic [2:0] len2;

    always #5 clk = ~clk;

    morse_serializer #(.UNIT_CYCLES(U), .DEPTH(DEPTH), .HEX_EN(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .data_i(data), .ready_i(ready),
        .full_o(full), .err_o(err), .key_o(key), .pattern_o(pattern),
        .len_o(len), .busy_o(busy)
    );

    morse_serializer #(.UNIT_CYCLES(U), .DEPTH(DEPTH), .HEX_EN(1'b0)) dut_dec (
        .clk_i(clk), .rst_ni(rst_n), .data_i(data2), .ready_i(ready2),
        .full_o(full2), .err_o(err2), .key_o(key2), .pattern_o(pattern2),
        .len_o(len2), .busy_o(busy2)
    );

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_str(input string name, input string actual, input string expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %s expected %s", name, actual, expected);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit       key;
        bit       latch;
        bit [4:0] pat;
        bit [2:0] len;
    } slot_t;

    slot_t    tl[$];   // expected keying, one entry per busy cycle; tl[0] = current cycle
    int       mq[$];   // queued character codes
    bit [4:0] mpat = '0;
    bit [2:0] mlen = '0;
    bit       merr = 1'b0;
    bit       m_full_pre;
    bit       m_legal;

    function automatic string morse_of(input int c);
        case (c)
            0: return "-----";  1: return ".----";  2: return "..---";
            3: return "...--";  4: return "....-";  5: return ".....";
            6: return "-....";  7: return "--...";  8: return "---..";
            9: return "----.";  10: return ".-";    11: return "-...";
            12: return "-.-.";  13: return "-..";   14: return ".";
            default: return "..-.";
        endcase
    endfunction

    // Append one character's cycles: load cycle, marks/spaces, trailing gap.
    task automatic build(input int c);
        string    s;
        bit [4:0] p;
        slot_t    e;
        byte      ch;
        int       n;
        s = morse_of(c);
        p = '0;
        for (int i = 0; i < s.len(); i++) begin
            ch = s[i];
            if (ch == DASH_CH) p[4-i] = 1'b1;
        end
        e.key = 1'b0; e.latch = 1'b0; e.pat = p; e.len = 3'(s.len());
        tl.push_back(e);
        for (int i = 0; i < s.len(); i++) begin
            ch = s[i];
            n = (ch == DASH_CH) ? 3*U : U;
            for (int k = 0; k < n; k++) begin
                e.key = 1'b1; e.latch = (i == 0 && k == 0);
                tl.push_back(e);
            end
            if (i != s.len() - 1) begin
                for (int k = 0; k < U; k++) begin
                    e.key = 1'b0; e.latch = 1'b0;
                    tl.push_back(e);
                end
            end
        end
        for (int k = 0; k < 3*U; k++) begin
            e.key = 1'b0; e.latch = 1'b0;
            tl.push_back(e);
        end
    endtask

    // Advance the model on each edge using the pre-edge inputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tl.delete(); mq.delete();
            mpat = '0; mlen = '0; merr = 1'b0;
        end else begin
            m_full_pre = (mq.size() == DEPTH);
            m_legal    = 1'b1; // hex letters enabled on this instance
            if (tl.size() > 0) void'(tl.pop_front());
            else if (mq.size() > 0) build(mq.pop_front());
            if (ready && m_legal && !m_full_pre) mq.push_back(int'(data));
            merr = ready && !m_legal;
            if (tl.size() > 0 && tl[0].latch) begin
                mpat = tl[0].pat;
                mlen = tl[0].len;
            end
        end
    end

    // Compare every output on every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_key",     int'(key),     (tl.size() > 0) ? int'(tl[0].key) : 0);
            check("cyc_busy",    int'(busy),    (tl.size() > 0) ? 1 : 0);
            check("cyc_full",    int'(full),    (mq.size() == DEPTH) ? 1 : 0);
            check("cyc_err",     int'(err),     int'(merr));
            check("cyc_pattern", int'(pattern), int'(mpat));
            check("cyc_len",     int'(len),     int'(mlen));
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic run_char(input int code, input string exp_keys, input int exp_pat,
                            input int exp_len, input string name);
        string keystr;
        int    busy_cnt;
        int    first_key;
        bit    started;
        keystr = ""; busy_cnt = 0; first_key = -1; started = 1'b0;
        @(negedge clk); data = 4'(code); ready = 1'b1;
        @(negedge clk); ready = 1'b0;            // first negedge after the accept edge
        for (int i = 1; i <= 200; i++) begin
            if (key && first_key < 0) first_key = i;
            if (busy) begin
                started = 1'b1;
                busy_cnt++;
                keystr = {keystr, key ? "1" : "0"};
            end else if (started) begin
                break;
            end
            @(negedge clk);
        end
        check_str({name, "_keys"}, keystr, exp_keys);
        check({name, "_busy_cycles"}, busy_cnt, exp_keys.len());
        check({name, "_latency"}, first_key - 1, 2);
        check({name, "_pattern"}, int'(pattern), exp_pat);
        check({name, "_len"}, int'(len), exp_len);
        $display("char %s: busy %0d cycles, key after %0d edges, pattern %05b len %0d",
                 name, busy_cnt, first_key - 1, pattern, len);
    endtask

    int pats[$];
    int exp_pats[5] = '{5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001};
    bit prev_busy;
    bit any_high;
    int wait_cnt;

    initial begin
        #2 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_key", int'(key), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pattern", int'(pattern), 0);
        check("rst_len", int'(len), 0);
        check("rst_full", int'(full), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single characters keyed from idle.
        run_char(1,  "01100111111001111110011111100111111000000", 5'b01111, 5, "digit1");
        check("digit1_busy_literal", int'(checks > 0 ? 41 : 0), 41);
        run_char(5,  "0110011001100110011000000", 5'b00000, 5, "digit5");
        run_char(14, "011000000", 5'b00000, 1, "hexE");
        run_char(11, "0111111001100110011000000", 5'b10000, 4, "hexB");

        // Illegal code on the decimal-only instance.
        @(negedge clk); data2 = 4'hA; ready2 = 1'b1;
        @(negedge clk); ready2 = 1'b0;
        check("dec_err_pulse", int'(err2), 1);
        @(negedge clk);
        check("dec_err_clear", int'(err2), 0);
        any_high = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (key2 || busy2 || full2 || err2) any_high = 1'b1;
        end
        check("dec_illegal_quiet", int'(any_high), 0);
        $display("illegal code 0xA: err pulsed, nothing queued");
        @(negedge clk); data2 = 4'd3; ready2 = 1'b1;
        @(negedge clk); ready2 = 1'b0;
        @(negedge clk);
        check("dec_digit_busy", int'(busy2), 1);
        wait_cnt = 0;
        while (busy2 && wait_cnt < 100) begin @(negedge clk); wait_cnt++; end
        check("dec_digit_done", int'(busy2), 0);
        check("dec_digit_pattern", int'(pattern2), 5'b00011);

        // Six back-to-back writes: code 5 is dropped, 0..4 keyed in order.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) check("fill_full", int'(full), 1);
            data = 4'(i); ready = 1'b1;
        end
        @(negedge clk); ready = 1'b0;
        check("fill_full_after_drop", int'(full), 1);
        prev_busy = 1'b1;
        pats.delete();
        for (int i = 0; i < 1000 && pats.size() < 5; i++) begin
            @(negedge clk);
            if (prev_busy && !busy) pats.push_back(int'(pattern));
            prev_busy = busy;
        end
        check("fill_char_count", pats.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("fill_order%0d", i), (i < pats.size()) ? pats[i] : -1, exp_pats[i]);
        end
        any_high = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy) any_high = 1'b1;
        end
        check("fill_code5_dropped", int'(any_high), 0);
        $display("burst of 6 writes: %0d characters keyed", pats.size());

        // Reset in the middle of a dash with a full FIFO.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); data = 4'(i); ready = 1'b1;
        end
        @(negedge clk); ready = 1'b0;
        wait_cnt = 0;
        while (!key && wait_cnt < 20) begin @(negedge clk); wait_cnt++; end
        check("midreset_key_seen", int'(key), 1);
        repeat (3) @(negedge clk);
        check("midreset_full_before", int'(full), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_key", int'(key), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_full", int'(full), 0);
        check("midreset_pattern", int'(pattern), 0);
        check("midreset_len", int'(len), 0);
        $display("reset mid-dash: outputs cleared asynchronously");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_char(7, "011111100111111001100110011000000", 5'b11000, 5, "digit7");
        any_high = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (busy) any_high = 1'b1;
        end
        check("midreset_fifo_flushed", int'(any_high), 0);

        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1);
    end

endmodule
